// File: rtl/display_scan_controller.sv
// Digit scan, frame-latched temperature and "Hi" scheduling for the 4-digit display.
// Optional: DISP_LEADING_ZERO_BLANK_EN blanks the tens digit for values below 10.
module display_scan_controller #(
  parameter logic [15:0] DWELL     = 16'd5000,
  parameter logic [15:0] BLANK     = 16'd50,
  parameter logic [7:0]  HI_FRAMES = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] temp_data,
  input  logic       temp_half,
  input  logic       temp_valid,
  input  logic       show_hi_req,
  output logic [1:0] select,
  output logic [3:0] digit_en,
  output logic [7:0] data_out,
  output logic       decimal_out,
  output logic       display_data,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    TEMP = 2'd0,
    ARM  = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dwell_cnt, dwell_d;
  logic [1:0]  select_d;
  logic [7:0]  shadow_data;
  logic        shadow_half;
  logic [7:0]  data_d;
  logic        half_d;
  logic [7:0]  frame_cnt, frame_cnt_d;
  logic        restart_q, restart_d;
  logic        dwell_tc;
  logic        boundary;
  logic        frame_done_d;
  logic [3:0]  digit_en_d;

  assign dwell_tc = (dwell_cnt == DWELL - 16'd1);
  assign boundary = dwell_tc && (select == 2'd3);

  always_comb begin
    dwell_d  = dwell_cnt + 16'd1;
    select_d = select;
    if (dwell_tc) begin
      dwell_d  = 16'd0;
      select_d = select + 2'd1;
    end
  end

  // Registered outputs are computed from the next counter values so they
  // stay aligned with select/dwell_cnt.
  assign frame_done_d = (select_d == 2'd3) &&
                        (dwell_d == DWELL - 16'd1);

  always_comb begin
    data_d = data_out;
    half_d = decimal_out;
    if (boundary) begin
      if (temp_valid) begin
        data_d = temp_data;
        half_d = temp_half;
      end else begin
        data_d = shadow_data;
        half_d = shadow_half;
      end
    end
  end

  // A request in HI restarts the count at the next boundary.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt;
    restart_d   = restart_q;
    unique case (state_q)
      TEMP: begin
        if (show_hi_req) state_d = ARM;
      end
      ARM: begin
        if (boundary) begin
          state_d     = HI;
          frame_cnt_d = 8'd0;
          restart_d   = 1'b0;
        end
      end
      HI: begin
        if (boundary) begin
          if (restart_q || show_hi_req) begin
            frame_cnt_d = 8'd0;
            restart_d   = 1'b0;
          end else if (frame_cnt + 8'd1 == HI_FRAMES) begin
            state_d     = TEMP;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt + 8'd1;
          end
        end else if (show_hi_req) begin
          frame_cnt_d = 8'd0;
          restart_d   = 1'b1;
        end
      end
      default: begin
        state_d     = TEMP;
        frame_cnt_d = 8'd0;
        restart_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    digit_en_d = 4'b0000;
    if (dwell_d >= BLANK) digit_en_d = 4'b0001 << select_d;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (state_d == TEMP && data_d < 8'd10) digit_en_d[3] = 1'b0;
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= TEMP;
      dwell_cnt    <= 16'd0;
      select       <= 2'd0;
      shadow_data  <= 8'd0;
      shadow_half  <= 1'b0;
      data_out     <= 8'd0;
      decimal_out  <= 1'b0;
      frame_cnt    <= 8'd0;
      restart_q    <= 1'b0;
      frame_done   <= 1'b0;
      digit_en     <= 4'b0000;
      display_data <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_cnt    <= dwell_d;
      select       <= select_d;
      data_out     <= data_d;
      decimal_out  <= half_d;
      frame_cnt    <= frame_cnt_d;
      restart_q    <= restart_d;
      frame_done   <= frame_done_d;
      digit_en     <= digit_en_d;
      display_data <= (state_d == HI);
      if (temp_valid) begin
        shadow_data <= temp_data;
        shadow_half <= temp_half;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (DWELL=8, BLANK=2, HI_FRAMES=3).
// Cycle-count reference model plus scoreboards for latched data and "Hi" length.
module tb_display_scan_controller;

  logic       clk;
  logic       reset;
  logic [7:0] temp_data;
  logic       temp_half;
  logic       temp_valid;
  logic       show_hi_req;
  logic [1:0] select;
  logic [3:0] digit_en;
  logic [7:0] data_out;
  logic       decimal_out;
  logic       display_data;
  logic       frame_done;

  display_scan_controller #(
    .DWELL(16'd8),
    .BLANK(16'd2),
    .HI_FRAMES(8'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .temp_data(temp_data),
    .temp_half(temp_half),
    .temp_valid(temp_valid),
    .show_hi_req(show_hi_req),
    .select(select),
    .digit_en(digit_en),
    .data_out(data_out),
    .decimal_out(decimal_out),
    .display_data(display_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int         k;
  int         mode;
  int         mleft;
  bit         ext;
  logic [8:0] msh;
  logic [8:0] mdout;
  int         fd_cnt;
  int         hi_len;

  logic [8:0] lat_q[$];
  int         hi_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    k      = 0;
    mode   = 0;
    mleft  = 0;
    ext    = 1'b0;
    msh    = 9'd0;
    mdout  = 9'd0;
    hi_len = 0;
    lat_q.delete();
    hi_q.delete();
  endtask

  task automatic step();
    bit         bnd;
    bit         tv;
    bit         rq;
    logic [8:0] din;
    logic [8:0] e;
    logic [3:0] eden;
    int         ecnt;
    int         esel;
    int         eh;
    bnd = (k % 32 == 31);
    tv  = temp_valid;
    rq  = show_hi_req;
    din = {temp_data, temp_half};
    @(posedge clk);
    #1;
    k++;
    if (tv) msh = din;
    if (bnd) mdout = msh;
    case (mode)
      0: if (rq) mode = 1;
      1: if (bnd) begin
        mode  = 2;
        mleft = 3;
        ext   = 1'b0;
      end
      default: begin
        if (bnd) begin
          if (ext || rq) begin
            mleft = 3;
            ext   = 1'b0;
          end else begin
            mleft--;
            if (mleft == 0) mode = 0;
          end
        end else if (rq) begin
          ext = 1'b1;
        end
      end
    endcase
    ecnt = k % 8;
    esel = (k / 8) % 4;
    eden = (ecnt >= 2) ? (4'b0001 << esel) : 4'b0000;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (mode == 0 && mdout[8:1] < 8'd10) eden[3] = 1'b0;
`endif
    chk("select", select, esel);
    chk("digit_en", digit_en, eden);
    chk("frame_done", frame_done, (k % 32 == 31));
    chk("display_data", display_data, (mode == 2));
    chk("data_out", data_out, mdout[8:1]);
    chk("decimal_out", decimal_out, mdout[0]);
    if (frame_done === 1'b1) fd_cnt++;
    if (bnd && lat_q.size() > 0) begin
      while (lat_q.size() > 1) void'(lat_q.pop_front());
      e = lat_q.pop_front();
      chk("sb_data", data_out, e[8:1]);
      chk("sb_half", decimal_out, e[0]);
    end
    if (display_data === 1'b1) begin
      hi_len++;
    end else if (hi_len > 0) begin
      eh = (hi_q.size() > 0) ? hi_q.pop_front() : 0;
      chk("hi_len", hi_len, eh);
      hi_len = 0;
    end
  endtask

  task automatic pulse_temp(input logic [7:0] d, input logic h);
    temp_data  = d;
    temp_half  = h;
    temp_valid = 1'b1;
    lat_q.push_back({d, h});
    step();
    temp_valid = 1'b0;
  endtask

  task automatic pulse_hi(input int exp_len);
    show_hi_req = 1'b1;
    if (exp_len > 0) hi_q.push_back(exp_len);
    step();
    show_hi_req = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_select", select, 2'd0);
    chk("rst_digit_en", digit_en, 4'd0);
    chk("rst_data_out", data_out, 8'd0);
    chk("rst_decimal", decimal_out, 1'b0);
    chk("rst_display", display_data, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int fd0;
    int d3;
    int guard;
    reset       = 1'b0;
    temp_data   = 8'd0;
    temp_half   = 1'b0;
    temp_valid  = 1'b0;
    show_hi_req = 1'b0;
    fd_cnt      = 0;
    model_init();

    do_reset();

    fd0 = fd_cnt;
    run(64);
    chk("frames_in_64", fd_cnt - fd0, 2);

    while ((k / 8) % 4 != 1) step();
    pulse_temp(8'd37, 1'b1);
    while (k % 32 != 0) step();
    chk("mid_update", data_out, 8'd37);

    while (k % 32 != 31) step();
    pulse_temp(8'd25, 1'b0);
    chk("bypass", data_out, 8'd25);

    run(5);
    pulse_temp(8'd40, 1'b0);
    run(3);
    pulse_temp(8'd41, 1'b1);
    while (k % 32 != 0) step();

    pulse_temp(8'd7, 1'b0);
    while (k % 32 != 0) step();
    d3 = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (digit_en[3] === 1'b1) d3++;
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    chk("tens_on_cycles", d3, 0);
`else
    chk("tens_on_cycles", d3, 6);
`endif

    run(4);
    pulse_hi(96);
    run(200);
    chk("hi_single_done", hi_q.size(), 0);

    pulse_hi(160);
    guard = 0;
    while (display_data !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    chk("hi_start", display_data, 1'b1);
    run(39);
    pulse_hi(0);
    run(200);
    chk("hi_ext_done", hi_q.size(), 0);

    while (k % 32 != 31) step();
    pulse_hi(96);
    run(10);
    chk("arm_on_boundary", display_data, 1'b0);
    guard = 0;
    while (!(mode == 2 && (k / 8) % 4 == 2) && guard < 100) begin
      step();
      guard++;
    end
    chk("in_hi_sel2", display_data, 1'b1);
    do_reset();
    run(40);
    chk("post_reset_temp", display_data, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequencing controller for the 4-digit seven-segment temperature display. It scans the 2-bit digit `select` across all four positions with a programmable dwell and an anti-ghosting blank interval, and drives the one-hot digit enables. It latches temperature data on frame boundaries so the binary-to-decimal digit converter never shows a torn value. It also schedules the timed "Hi" message by driving `display_data`. It sits between the sensor/control logic and the binary-to-decimal converter, and its outputs feed that converter's `select`, `data`, `decimal` and `display_data` inputs directly.

## Interface
- `DWELL`, 16'd5000: clock cycles each digit is selected; must be ≥ `BLANK`+1.
- `BLANK`, 16'd50: cycles at the start of each dwell with all digit enables off; must be ≥ 1.
- `HI_FRAMES`, 8'd100: full frames the "Hi" message stays up per request; must be ≥ 1.
- `clk` in 1: single clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `temp_data` in 8: integer temperature to display.
- `temp_half` in 1: 0.5-degree flag, sampled together with `temp_data`.
- `temp_valid` in 1: one-cycle strobe that qualifies `temp_data`/`temp_half`.
- `show_hi_req` in 1: one-cycle strobe requesting the "Hi" message.
- `select` out 2: digit index to the converter (0 = rightmost).
- `digit_en` out 4: one-hot, active-high digit drive.
- `data_out` out 8: frame-stable temperature to the converter.
- `decimal_out` out 1: frame-stable half-degree flag.
- `display_data` out 1: 1 = "Hi" message, 0 = temperature.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Reset values:** all outputs are 0, `dwell_cnt` = 0, the shadow registers are 0, and the FSM is in TEMP.
- **Shadow update:** on `temp_valid`, the shadow registers capture {`temp_data`, `temp_half`}. The newest strobe always wins.
- **Dwell counter:** counts 0..`DWELL`-1. At terminal count, `dwell_cnt` returns to 0 and `select` increments. `select` wraps from 3 to 0.
- **Digit enable:** `digit_en` = 4'b0001 << `select` while `BLANK` ≤ `dwell_cnt` ≤ `DWELL`-1, and 0 otherwise. Exactly one bit or none is ever high.
- **Frame boundary:** the cycle in which `select` wraps from 3 to 0. In that cycle:
  - `frame_done` pulses.
  - `data_out`/`decimal_out` load the shadow registers.
  - If `temp_valid` is high in the same cycle, they load `temp_data`/`temp_half` directly (bypass).
- **FSM states:**
  - TEMP: `display_data` = 0.
  - ARM: "Hi" is pending; `display_data` = 0.
  - HI: `display_data` = 1.
- **FSM transitions:**
  - TEMP → ARM on `show_hi_req`.
  - ARM → HI at the next frame boundary. The frame counter clears at that point.
  - HI increments the frame counter at each boundary.
  - HI → TEMP at the boundary where the count reaches `HI_FRAMES`.
- **Simultaneous events:**
  - `show_hi_req` in ARM is ignored.
  - `show_hi_req` in HI clears the frame counter, extending the message by `HI_FRAMES` frames from the next boundary.
  - `show_hi_req` in TEMP on a boundary cycle goes to ARM only; the message starts at the following boundary.
- **Temperature during HI:** temperature keeps being shadowed and latched while in HI, so the correct value is shown immediately on return to TEMP.

## Timing
- `select` and `display_data` change only at dwell boundaries or frame boundaries, so there are no mid-digit changes.
- Frame length is 4·`DWELL` cycles. `frame_done` has a period of 4·`DWELL` cycles.
- Latency from `temp_valid` to `data_out` is between 1 cycle and 4·`DWELL` cycles, taking effect at the next frame boundary.
- "Hi" starts 1 to 4·`DWELL` cycles after the request and lasts exactly `HI_FRAMES`·4·`DWELL` cycles.
- All outputs are registered. Asserting `reset` forces the reset values immediately, with no clock edge required; operation resumes from `select` = 0, `dwell_cnt` = 0 on the first edge after release.

## Configuration
- **`DISP_LEADING_ZERO_BLANK_EN` defined:**
  - While in TEMP and latched `data_out` < 10, `digit_en[3]` is held at 0, so there is no leading zero in the tens position.
  - `select` timing is unchanged.
- **Not defined:** all four digits are always enabled per the rule in Operation.

## Test plan
Unless stated otherwise, scenarios use `DWELL`=8, `BLANK`=2, `HI_FRAMES`=3.

1. **Free-running scan:** release reset with no other stimulus → `select` steps 0,1,2,3 every 8 cycles; the one-hot `digit_en` is high for `dwell_cnt` 2–7; `frame_done` fires every 32 cycles; `data_out` = 0.
2. **Mid-frame update:** pulse `temp_valid` with 8'd37, `temp_half`=1, at `select`=1 → `data_out` stays at its old value until the next `frame_done` cycle, then becomes 37 with `decimal_out`=1.
3. **Bypass on boundary:** pulse `temp_valid` with 8'd25 exactly in a `frame_done` cycle → `data_out` = 25 in that same boundary update.
4. **Hi scheduling:**
   - Pulse `show_hi_req` once → `display_data`=1 from the next boundary for exactly 96 cycles, then 0.
   - A second request at frame 2 of HI → total high time of 2·32 + 96 = 160 cycles.
5. **Leading-zero blank:** latch `data_out` = 7.
   - With `DISP_LEADING_ZERO_BLANK_EN` defined → `digit_en[3]` is never high.
   - Without it → `digit_en[3]` is high 6 cycles per frame.
6. **Reset mid-operation:** assert `reset` asynchronously at `select`=2 during HI → all outputs are 0 before the next clock edge; after release the controller is in TEMP with `select`=0.
